// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default board bit timing
// (12 MHz system clock, 19200 baud).
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 625;
  localparam int DEF_CNT_SIZE     = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Offset of the mid-bit sample point from the start-bit falling edge.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen to match the idle level of the line being synchronized.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: synchronizes rx, times bits with an internal counter and
// presents each correctly framed byte LSB-first with a one-cycle rx_valid strobe.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_SIZE     = DEF_CNT_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_SIZE-1:0] HALF_LAST = CNT_SIZE'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CNT_SIZE-1:0] BIT_LAST  = CNT_SIZE'(CLKS_PER_BIT - 1);

  logic                rx_s;
  rx_state_e           state, state_nx;
  logic [CNT_SIZE-1:0] cnt, cnt_nx;
  logic [2:0]          bit_idx, bit_idx_nx;
  logic [7:0]          shift, shift_nx;
  logic [7:0]          rxbyte_nx;
  logic                rx_valid_nx;
  logic                frame_err_nx;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rxbyte    <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shift     <= shift_nx;
      rxbyte    <= rxbyte_nx;
      rx_valid  <= rx_valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bit_idx_nx   = bit_idx;
    shift_nx     = shift;
    rxbyte_nx    = rxbyte;
    rx_valid_nx  = 1'b0;
    frame_err_nx = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end

      // Re-check the start bit at its middle; a short low pulse is a glitch.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (!rx_s) begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          shift_nx   = {rx_s, shift[7:1]};
          cnt_nx     = '0;
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      // Returning to IDLE on the stop sample itself leaves half a bit of
      // slack for a start bit that follows immediately.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            rxbyte_nx   = shift;
            rx_valid_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = WAIT_HIGH;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      // A held-low line (break) must not be seen as a fresh start bit.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 16 clocks per bit: framing, back-to-back
// frames, glitch rejection, framing error with break, reset abort and an a..z stream.
module tb_uart_rx_8n1;

  localparam int CPB = 16;
  localparam int CS  = 5;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rxbyte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic both_high = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CPB),
    .CNT_SIZE    (CS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rxbyte   (rxbyte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: start bit and 8 data bits LSB first; stop_low_bits == 0 gives a
  // normal high stop bit, otherwise the line is left low for that many bit times.
  task automatic send_frame(input logic [7:0] d, input int stop_low_bits);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low_bits == 0) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (CPB * stop_low_bits) @(negedge clk);
    end
  endtask

  // Scoreboard: every rx_valid must match the head of exp_q.
  always @(negedge clk) begin
    if (rx_valid && frame_err) both_high = 1'b1;
    if (rx_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        check("rxbyte_stream", {24'd0, rxbyte}, {24'd0, exp_b});
      end
    end
    if (frame_err) ferr_cnt++;
  end

  initial begin
    int v0, f0, lat, gap;

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rxbyte",    {24'd0, rxbyte}, 32'h00);
    check("reset_rx_valid",  {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy",      {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame 8'h41 and its latency from the rx falling edge
    exp_q.push_back(8'h41);
    send_frame(8'h41, 0);
    lat = last_valid_cyc - fall_cyc;
    check("t1_valid_count", valid_cnt, 32'd1);
    check("t1_ferr_count",  ferr_cnt, 32'd0);
    check("t1_rxbyte",      {24'd0, rxbyte}, 32'h41);
    check("t1_busy_low",    {31'd0, busy}, 32'd0);
    check("t1_latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    repeat (10) @(negedge clk);

    // Back-to-back 8'h00 then 8'hFF, no idle between frames
    v0 = valid_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    gap = last_valid_cyc - prev_valid_cyc;
    check("t2_valid_count", valid_cnt - v0, 32'd2);
    check("t2_gap_160pm1",  {31'd0, (gap >= 159 && gap <= 161)}, 32'd1);
    check("t2_rxbyte",      {24'd0, rxbyte}, 32'hFF);
    check("t2_queue_empty", exp_q.size(), 32'd0);
    repeat (10) @(negedge clk);

    // 4-clock glitch: START entered, then rejected at the half-bit point
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_busy_in_start", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (9) @(negedge clk);
    check("t3_busy_low", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("t3_no_valid", valid_cnt - v0, 32'd0);
    check("t3_no_ferr",  ferr_cnt - f0, 32'd0);

    // 8'h5A with stop held low for 3 bit times
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h5A, 3);
    check("t4_ferr_pulse",       ferr_cnt - f0, 32'd1);
    check("t4_no_valid",         valid_cnt - v0, 32'd0);
    check("t4_rxbyte_held",      {24'd0, rxbyte}, 32'hFF);
    check("t4_busy_in_wait_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_no_new_frame_valid", valid_cnt - v0, 32'd0);
    check("t4_no_new_frame_ferr",  ferr_cnt - f0, 32'd1);
    check("t4_busy_low",           {31'd0, busy}, 32'd0);

    // Reset during data bit 4 of 8'hC3; the transmitter abandons the frame
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = logic'((8'hC3 >> i) & 8'h01);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_abort_no_valid", valid_cnt - v0, 32'd0);
    check("t5_abort_no_ferr",  ferr_cnt - f0, 32'd0);
    check("t5_rxbyte_reset",   {24'd0, rxbyte}, 32'h00);
    check("t5_busy_low",       {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0);
    check("t5_valid_after", valid_cnt - v0, 32'd1);
    check("t5_rxbyte_3c",   {24'd0, rxbyte}, 32'h3C);
    repeat (10) @(negedge clk);

    // Stream 'a'..'z' back to back
    v0 = valid_cnt;
    f0 = ferr_cnt;
    for (int c = 8'h61; c <= 8'h7A; c++) begin
      exp_q.push_back(8'(c));
      send_frame(8'(c), 0);
    end
    repeat (10) @(negedge clk);
    check("t6_valid_count", valid_cnt - v0, 32'd26);
    check("t6_no_ferr",     ferr_cnt - f0, 32'd0);
    check("t6_queue_empty", exp_q.size(), 32'd0);
    check("t6_rxbyte_z",    {24'd0, rxbyte}, 32'h7A);

    check("valid_ferr_never_together", {31'd0, both_high}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
